// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART constants, the byte type and the baud divisor helper.
// Used by uart_rx_ctrl and uart_baud_gen.
package uart_rx_ctrl_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Divisor value for a given clock and baud rate: f_clk/(16*baud) - 1.
  function automatic int unsigned uart_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / (UART_OVERSAMPLE * baud) - 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable oversample tick generator: counts 0..divisor and emits a registered
// one-cycle tick in the cycle where count == divisor. Shared with the transmitter.
module uart_baud_gen
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             en,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // A count already past a freshly lowered divisor wraps to 0; it only ticks if divisor is 0.
  always_comb begin
    count_d = '0;
    tick_d  = 1'b0;
    if (en) begin
      if (count_q < divisor) count_d = count_q + 1'b1;
      tick_d = (count_d == divisor);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive front-end: baud tick, rx edge detect, FWFT byte FIFO, overrun and error count.
// Define UART_RX_CTRL_KEEP_ERR_EN to also queue errored frames, flagged on m_err.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       en,
  input  logic [DIV_W-1:0]           divisor,
  input  logic                       clr,
  output logic                       uart_clk,
  input  logic                       rx_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_error,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic [ERR_W-1:0]           err_cnt
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  ,
  output logic                       m_err
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  localparam int unsigned ENTRY_W = UART_DATA_W + 1;
`else
  localparam int unsigned ENTRY_W = UART_DATA_W;
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overrun_q, overrun_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               rx_ready_q, rx_error_q;
  logic               push, err_ev, wr_req, pop, full, do_wr;
  logic [ENTRY_W-1:0] wr_entry;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk     (clk),
    .nRST    (nRST),
    .en      (en),
    .divisor (divisor),
    .tick    (uart_clk)
  );

  assign push   = rx_ready & ~rx_ready_q;
  assign err_ev = rx_error & ~rx_error_q;

`ifdef UART_RX_CTRL_KEEP_ERR_EN
  // A good-frame and error edge in the same cycle collapse into one flagged entry.
  assign wr_req   = push | err_ev;
  assign wr_entry = {err_ev, rx_data};
`else
  assign wr_req   = push;
  assign wr_entry = rx_data;
`endif

  assign full  = (level_q == LVL_W'(DEPTH));
  assign pop   = (level_q != '0) & m_ready;
  assign do_wr = wr_req & (~full | pop);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;

    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({do_wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (wr_req && full && !pop) overrun_d = 1'b1;
    if (err_ev && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;

    if (clr) begin
      overrun_d = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      err_cnt_q  <= '0;
      rx_ready_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      err_cnt_q  <= err_cnt_d;
      rx_ready_q <= rx_ready;
      rx_error_q <= rx_error;
    end
  end

  assign m_valid = (level_q != '0);
  assign m_data  = mem_q[rd_ptr_q][7:0];
  assign level   = level_q;
  assign overrun = overrun_q;
  assign err_cnt = err_cnt_q;
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  assign m_err   = mem_q[rd_ptr_q][8];
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with a queue scoreboard of expected FIFO entries.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ERR_W = 2;

  logic        clk = 1'b0;
  logic        nRST, en, clr, rx_ready, rx_error, m_ready;
  logic [15:0] divisor;
  logic [7:0]  rx_data, m_data;
  logic        uart_clk, m_valid, overrun;
  logic [2:0]  level;
  logic [1:0]  err_cnt;
`ifdef UART_RX_CTRL_KEEP_ERR_EN
  logic        m_err;
`endif

  int          n_chk = 0;
  int          n_pass = 0;
  logic [8:0]  sb[$];
  logic        exp_ovr = 1'b0;
  int          exp_err = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DIV_W(16), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .nRST     (nRST),
    .en       (en),
    .divisor  (divisor),
    .clr      (clr),
    .uart_clk (uart_clk),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .overrun  (overrun),
    .err_cnt  (err_cnt)
`ifdef UART_RX_CTRL_KEEP_ERR_EN
    ,
    .m_err    (m_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step();
    if (sb.size() < DEPTH) sb.push_back({1'b0, b});
    else exp_ovr = 1'b1;
    rx_ready = 1'b0;
    step();
  endtask

  task automatic err_frame(input logic [7:0] b);
    rx_data  = b;
    rx_error = 1'b1;
    step();
    if (exp_err < 3) exp_err++;
`ifdef UART_RX_CTRL_KEEP_ERR_EN
    if (sb.size() < DEPTH) sb.push_back({1'b1, b});
    else exp_ovr = 1'b1;
`endif
    chk("err_cnt_inc", 32'(err_cnt), 32'(exp_err));
    rx_error = 1'b0;
    step();
  endtask

  task automatic pop_one();
    logic [8:0] e;
    e = sb.pop_front();
    chk("pop_valid", 32'(m_valid), 32'd1);
    chk("pop_data", 32'(m_data), 32'(e[7:0]));
`ifdef UART_RX_CTRL_KEEP_ERR_EN
    chk("pop_err", 32'(m_err), 32'(e[8]));
`endif
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() > 0) pop_one();
    chk("drained_valid", 32'(m_valid), 32'd0);
    chk("drained_level", 32'(level), 32'd0);
  endtask

  initial begin
    nRST = 1'b0; en = 1'b0; clr = 1'b0; rx_ready = 1'b0; rx_error = 1'b0;
    m_ready = 1'b0; divisor = 16'd0; rx_data = 8'h00;
    repeat (3) step();
    chk("rst_uart_clk", 32'(uart_clk), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    nRST = 1'b1;
    step();

    // divisor=3: after i edges the count is i mod 4, ticking when it reaches 3
    divisor = 16'd3;
    en      = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("tick_div3", 32'(uart_clk), 32'((i % 4) == 3));
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("tick_en_off", 32'(uart_clk), 32'd0);
    end
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("tick_restart", 32'(uart_clk), 32'((i % 4) == 3));
    end
    divisor = 16'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tick_div0", 32'(uart_clk), 32'd1);
    end
    en = 1'b0;
    step();

    // single frame, no bypass, held rx_ready gives only one push
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    #1;
    chk("no_bypass", 32'(m_valid), 32'd0);
    step();
    sb.push_back({1'b0, 8'hA5});
    chk("first_valid", 32'(m_valid), 32'd1);
    chk("first_data", 32'(m_data), 32'hA5);
    chk("first_level", 32'(level), 32'd1);
    repeat (50) step();
    chk("held_level", 32'(level), 32'd1);
    rx_ready = 1'b0;
    step();
    drain();

    // overflow with five frames
    for (int k = 1; k <= 5; k++) send(8'(k));
    chk("full_level", 32'(level), 32'd4);
    chk("full_overrun", 32'(overrun), 32'(exp_ovr));
    chk("full_head", 32'(m_data), 32'h01);
    drain();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_ovr = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);

    // simultaneous push and pop on a full FIFO
    for (int k = 1; k <= 4; k++) send(8'(k));
    rx_data  = 8'h05;
    rx_ready = 1'b1;
    m_ready  = 1'b1;
    chk("pp_head_before", 32'(m_data), 32'(sb[0][7:0]));
    step();
    void'(sb.pop_front());
    sb.push_back({1'b0, 8'h05});
    rx_ready = 1'b0;
    m_ready  = 1'b0;
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_overrun", 32'(overrun), 32'd0);
    chk("pp_next_head", 32'(m_data), 32'(sb[0][7:0]));
    step();
    drain();

    // error counter saturation; clr beats a coincident error edge and overflow drop
    for (int k = 0; k < 4; k++) send(8'h10 + 8'(k));
    for (int k = 0; k < 5; k++) err_frame(8'hE0 + 8'(k));
    chk("err_sat", 32'(err_cnt), 32'd3);
    chk("err_ovr", 32'(overrun), 32'(exp_ovr));
    rx_data  = 8'hEE;
    rx_error = 1'b1;
    rx_ready = 1'b1;
    clr      = 1'b1;
    step();
    clr = 1'b0;
    exp_err = 0;
    exp_ovr = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("clr_drop_overrun", 32'(overrun), 32'(exp_ovr));
    chk("clr_keeps_level", 32'(level), 32'd4);
    rx_error = 1'b0;
    rx_ready = 1'b0;
    step();
    drain();

    // asynchronous reset discards buffered bytes
    for (int k = 0; k < 3; k++) send(8'h30 + 8'(k));
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_rst_valid", 32'(m_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    sb.delete();
    #1;
    nRST = 1'b1;
    step();

`ifdef UART_RX_CTRL_KEEP_ERR_EN
    rx_data  = 8'h7E;
    rx_error = 1'b1;
    step();
    sb.push_back({1'b1, 8'h7E});
    rx_error = 1'b0;
    chk("keep_err_data", 32'(m_data), 32'h7E);
    chk("keep_err_flag", 32'(m_err), 32'd1);
    step();
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
